// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back scheduler.
package wb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int REG_ZERO   = 0;

    typedef enum logic {
        PIPE_PRI = 1'b0,
        DRAIN    = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order result buffer for MDU writes; power-of-two depth.
module wb_result_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single RF write port between write-back and the MDU.
// Define WB_FWD_EN to expose the combinational forwarding outputs.
module wb_port_scheduler
    import wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pipe_wb_valid,
    input  logic [ADDR_W-1:0]             pipe_wb_addr,
    input  logic [DATA_W-1:0]             pipe_wb_data,
    output logic                          pipe_stall,
    input  logic                          mdu_valid,
    input  logic [ADDR_W-1:0]             mdu_addr,
    input  logic [DATA_W-1:0]             mdu_data,
    output logic                          mdu_ready,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_FWD_EN
    ,
    output logic                          fwd_valid,
    output logic [ADDR_W-1:0]             fwd_addr,
    output logic [DATA_W-1:0]             fwd_data
`endif
);

    wb_state_t           state;
    logic [3:0]          starve_cnt;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                bypass;
    logic                grant;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    wb_result_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({mdu_addr, mdu_data}),
        .dout  ({head_addr, head_data}),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign mdu_ready  = !full;
    assign pipe_stall = (state == DRAIN);
    assign push       = mdu_valid && mdu_ready && !bypass;

    always_comb begin
        pop    = 1'b0;
        bypass = 1'b0;
        grant  = 1'b0;
        g_addr = pipe_wb_addr;
        g_data = pipe_wb_data;
        case (state)
            DRAIN: begin
                if (!empty) begin
                    pop    = 1'b1;
                    grant  = 1'b1;
                    g_addr = head_addr;
                    g_data = head_data;
                end
            end
            default: begin
                if (pipe_wb_valid) begin
                    grant = 1'b1;
                end else if (!empty) begin
                    pop    = 1'b1;
                    grant  = 1'b1;
                    g_addr = head_addr;
                    g_data = head_data;
                end else if (mdu_valid) begin
                    // Empty FIFO: skip it so the result lands a cycle earlier.
                    bypass = 1'b1;
                    grant  = 1'b1;
                    g_addr = mdu_addr;
                    g_data = mdu_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PIPE_PRI;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            rf_we <= grant && (g_addr != ADDR_W'(REG_ZERO));
            if (grant) begin
                rf_waddr <= g_addr;
                rf_wdata <= g_data;
            end
            if (state == DRAIN) begin
                state      <= PIPE_PRI;
                starve_cnt <= '0;
            end else if (empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt == 4'(STARVE_MAX - 1)) begin
                state      <= DRAIN;
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = reset && grant && (g_addr != ADDR_W'(REG_ZERO));
    assign fwd_addr  = g_addr;
    assign fwd_data  = g_data;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Randomized bench for wb_port_scheduler against a queue-based reference model.
module tb_wb_port_scheduler;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          pipe_wb_valid;
    logic [AW-1:0] pipe_wb_addr;
    logic [DW-1:0] pipe_wb_data;
    logic          pipe_stall;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [1:0]    fifo_count;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    wb_port_scheduler #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pipe_wb_valid (pipe_wb_valid),
        .pipe_wb_addr  (pipe_wb_addr),
        .pipe_wb_data  (pipe_wb_data),
        .pipe_stall    (pipe_stall),
        .mdu_valid     (mdu_valid),
        .mdu_addr      (mdu_addr),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fifo_count    (fifo_count)
`ifdef WB_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: queue of pending MDU results, how long the head has
    // waited without being written, and whether a forced drain is due.
    logic [AW+DW-1:0] q[$];
    bit               m_drain;
    int               m_wait;
    bit               e_we;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_data;

    task automatic model_reset();
        q.delete();
        m_drain = 0;
        m_wait  = 0;
        e_we    = 0;
        e_addr  = '0;
        e_data  = '0;
    endtask

    task automatic step(input bit pv, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pd, input bit mv,
                        input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        output bit accepted, output bit stalled);
        bit            ready;
        bit            had;
        bit            g;
        bit            popped;
        bit            byp;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        pipe_wb_valid = pv;
        pipe_wb_addr  = pa;
        pipe_wb_data  = pd;
        mdu_valid     = mv;
        mdu_addr      = ma;
        mdu_data      = md;
        #1;
        ready = q.size() < DEPTH;
        check("mdu_ready", mdu_ready, ready);
        check("pipe_stall", pipe_stall, m_drain);
        check("fifo_count", fifo_count, q.size());
        stalled  = m_drain;
        accepted = mv && ready;
        had      = q.size() != 0;
        g = 0; popped = 0; byp = 0; ga = '0; gd = '0;
        if (m_drain) begin
            if (had) begin
                {ga, gd} = q.pop_front();
                g = 1; popped = 1;
            end
            m_drain = 0;
            m_wait  = 0;
        end else begin
            if (pv) begin
                g = 1; ga = pa; gd = pd;
            end else if (had) begin
                {ga, gd} = q.pop_front();
                g = 1; popped = 1;
            end else if (mv) begin
                g = 1; byp = 1; ga = ma; gd = md;
            end
            if (!had || popped) m_wait = 0;
            else if (m_wait == SMAX - 1) begin
                m_drain = 1;
                m_wait  = 0;
            end else m_wait++;
        end
        if (accepted && !byp) q.push_back({ma, md});
`ifdef WB_FWD_EN
        check("fwd_valid", fwd_valid, g && ga != 0);
`endif
        e_we = g && ga != 0;
        if (g) begin
            e_addr = ga;
            e_data = gd;
        end
        @(posedge clk);
        #1;
        check("rf_we", rf_we, e_we);
        if (e_we) begin
            check("rf_waddr", rf_waddr, e_addr);
            check("rf_wdata", rf_wdata, e_data);
        end
        @(negedge clk);
    endtask

    bit            acc;
    bit            st;
    bit            pv;
    bit            mv;
    logic [AW-1:0] pa;
    logic [AW-1:0] ma;
    logic [DW-1:0] pd;
    logic [DW-1:0] md;
    int            idx;
    int            first_stall;
    int            n_stall;
    logic [AW-1:0] ord_a[3];
    logic [DW-1:0] ord_d[3];

    initial begin
        reset = 1'b0;
        pipe_wb_valid = 1; pipe_wb_addr = 3; pipe_wb_data = 8'hFF;
        mdu_valid = 1; mdu_addr = 5; mdu_data = 8'hA5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_stall", pipe_stall, 0);
        check("rst_ready", mdu_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        @(negedge clk);
        reset = 1'b1;

        // Pipe-only writes, then a register-0 write.
        step(1, 3, 8'hFF, 0, 0, 0, acc, st);
        step(1, 0, 8'h0F, 0, 0, 0, acc, st);
        // Bypass through an empty FIFO.
        step(0, 0, 0, 1, 5, 8'hA5, acc, st);
        check("bypass_acc", acc, 1);
        step(0, 0, 0, 0, 0, 0, acc, st);

        // Pipe busy while three MDU results are offered.
        ord_a[0] = 6; ord_d[0] = 8'h11;
        ord_a[1] = 7; ord_d[1] = 8'h22;
        ord_a[2] = 2; ord_d[2] = 8'h33;
        idx = 0; pd = 8'h40;
        for (int c = 0; c < 14; c++) begin
            mv = idx < 3;
            step(1, 1, pd, mv, ord_a[idx % 3], ord_d[idx % 3], acc, st);
            if (c == 2) check("full_count", fifo_count, 2);
            if (acc) idx++;
            if (!st) pd++;
        end
        check("all_accepted", idx, 3);
        repeat (4) step(0, 0, 0, 0, 0, 0, acc, st);

        // Starvation: one push at cycle 0, forced stall at cycle 5.
        first_stall = -1; n_stall = 0; pd = 8'h80;
        for (int c = 0; c < 10; c++) begin
            step(1, 4, pd, c == 0, 6, 8'h5A, acc, st);
            if (st) begin
                n_stall++;
                if (first_stall < 0) first_stall = c;
            end else pd++;
        end
        check("stall_cycle", first_stall, 5);
        check("stall_count", n_stall, 1);

        // Reset while a drain is pending.
        pd = 8'h90;
        for (int c = 0; c < 10 && !m_drain; c++) begin
            step(1, 4, pd, c == 0, 6, 8'h77, acc, st);
            pd++;
        end
        check("drain_reached", m_drain, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_stall", pipe_stall, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_ready", mdu_ready, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic honoring the stall and valid-hold protocols.
        pv = 0; mv = 0; pa = '0; ma = '0; pd = '0; md = '0; st = 0; acc = 0;
        for (int c = 0; c < 500; c++) begin
            if (!(st && pv)) begin
                pv = $urandom_range(0, 99) < 60;
                pa = AW'($urandom_range(0, 7));
                pd = DW'($urandom);
            end
            if (!(mv && !acc)) begin
                mv = $urandom_range(0, 99) < 45;
                ma = AW'($urandom_range(0, 7));
                md = DW'($urandom);
            end
            step(pv, pa, pd, mv, ma, md, acc, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
